// File: rtl/gpr_if.sv
// Bus between the execute-stage write controller and the register file:
// write commands and data in, read data, special-register views and port latches out.
interface gpr_if #(
   parameter int DATA_WIDTH = 8
);
   logic [2:0]            writeCommand;
   logic [DATA_WIDTH-1:0] gprWriteDataIn;
   logic [DATA_WIDTH-1:0] statusWriteIn;
   logic                  tmr0Inc;
   logic [DATA_WIDTH-1:0] portAIn;
   logic [DATA_WIDTH-1:0] portBIn;
   logic [DATA_WIDTH-1:0] portCIn;
   logic [DATA_WIDTH-1:0] portAOut;
   logic [DATA_WIDTH-1:0] portBOut;
   logic [DATA_WIDTH-1:0] portCOut;
   logic [DATA_WIDTH-1:0] gprReadDataOut;
   logic [DATA_WIDTH-1:0] gprStatusOut;
   logic [DATA_WIDTH-1:0] fsrOut;
   logic                  pclWriteEn;
   logic [DATA_WIDTH-1:0] pclWriteData;

   modport master (
      output writeCommand, gprWriteDataIn, statusWriteIn, tmr0Inc,
             portAIn, portBIn, portCIn,
      input  portAOut, portBOut, portCOut, gprReadDataOut, gprStatusOut,
             fsrOut, pclWriteEn, pclWriteData
   );

   modport slave (
      input  writeCommand, gprWriteDataIn, statusWriteIn, tmr0Inc,
             portAIn, portBIn, portCIn,
      output portAOut, portBOut, portCOut, gprReadDataOut, gprStatusOut,
             fsrOut, pclWriteEn, pclWriteData
   );
endinterface

// File: rtl/gpr_file.sv
// Register file: address latch, special registers (TMR0, PCL, STATUS, FSR, ports),
// general-purpose RAM and INDF indirection through FSR; reads are combinational.
module gpr_file #(
   parameter int                    DATA_WIDTH   = 8,
   parameter int                    ADDR_WIDTH   = 5,
   parameter logic [DATA_WIDTH-1:0] STATUS_RESET = 8'h18
) (
   input logic   clk,
   input logic   rst_n,
   gpr_if.slave  bus
);
   localparam int GPR_BASE = 8;
   localparam int GPR_CNT  = (2 ** ADDR_WIDTH) - GPR_BASE;
   localparam int IDX_W    = $clog2(GPR_CNT);

   localparam logic [ADDR_WIDTH-1:0] A_INDF   = ADDR_WIDTH'(0);
   localparam logic [ADDR_WIDTH-1:0] A_TMR0   = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] A_PCL    = ADDR_WIDTH'(2);
   localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(3);
   localparam logic [ADDR_WIDTH-1:0] A_FSR    = ADDR_WIDTH'(4);
   localparam logic [ADDR_WIDTH-1:0] A_PORTA  = ADDR_WIDTH'(5);
   localparam logic [ADDR_WIDTH-1:0] A_PORTB  = ADDR_WIDTH'(6);
   localparam logic [ADDR_WIDTH-1:0] A_PORTC  = ADDR_WIDTH'(7);
   localparam logic [ADDR_WIDTH-1:0] A_GPR    = ADDR_WIDTH'(GPR_BASE);

   logic [ADDR_WIDTH-1:0] addrQ;
   logic [ADDR_WIDTH-1:0] effA;
   logic [IDX_W-1:0]      gprIdx;
   logic [DATA_WIDTH-1:0] statusQ;
   logic [DATA_WIDTH-1:0] statusNext;
   logic [DATA_WIDTH-1:0] fsrQ;
   logic [DATA_WIDTH-1:0] tmr0Q;
   logic [1:0]            inhibitQ;
   logic [DATA_WIDTH-1:0] portAQ;
   logic [DATA_WIDTH-1:0] portBQ;
   logic [DATA_WIDTH-1:0] portCQ;
   logic [DATA_WIDTH-1:0] pclDataQ;
   logic                  pclEnQ;
   logic [DATA_WIDTH-1:0] gprMem [GPR_CNT];
   logic [DATA_WIDTH-1:0] rdData;
   logic [DATA_WIDTH-1:0] wrData;
   logic                  wrEn;
   logic                  unusedStatusBits;

   assign unusedStatusBits = &{1'b0, bus.statusWriteIn[DATA_WIDTH-1:3]};

   // Address 0 is INDF: redirect through FSR; an FSR that also points at 0 is a null target.
   always_comb begin
      effA   = (addrQ == A_INDF) ? fsrQ[ADDR_WIDTH-1:0] : addrQ;
      gprIdx = IDX_W'(effA - A_GPR);
      wrData = bus.gprWriteDataIn;
      wrEn   = bus.writeCommand[1];
   end

   always_comb begin
      rdData = '0;
      if (effA >= A_GPR) begin
         rdData = gprMem[gprIdx];
      end else begin
         case (effA)
            A_TMR0:   rdData = tmr0Q;
            A_PCL:    rdData = pclDataQ;
            A_STATUS: rdData = statusQ;
            A_FSR:    rdData = fsrQ;
            A_PORTA:  rdData = bus.portAIn;
            A_PORTB:  rdData = bus.portBIn;
            A_PORTC:  rdData = bus.portCIn;
            default:  rdData = '0;
         endcase
      end
   end

   // TO/PD are never writable; the flag-update command overrides the data write on [2:0].
   always_comb begin
      statusNext = statusQ;
      if (wrEn && effA == A_STATUS) begin
         statusNext[7:5] = wrData[7:5];
         statusNext[2:0] = wrData[2:0];
      end
      if (bus.writeCommand[0]) begin
         statusNext[2:0] = bus.statusWriteIn[2:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addrQ    <= '0;
         statusQ  <= STATUS_RESET;
         fsrQ     <= '0;
         tmr0Q    <= '0;
         inhibitQ <= '0;
         portAQ   <= '0;
         portBQ   <= '0;
         portCQ   <= '0;
         pclDataQ <= '0;
         pclEnQ   <= 1'b0;
      end else begin
         if (bus.writeCommand[2]) begin
            addrQ <= wrData[ADDR_WIDTH-1:0];
         end
         statusQ <= statusNext;
         pclEnQ  <= wrEn && (effA == A_PCL);
         if (wrEn && effA == A_PCL)   pclDataQ <= wrData;
         if (wrEn && effA == A_FSR)   fsrQ     <= wrData;
         if (wrEn && effA == A_PORTA) portAQ   <= wrData;
         if (wrEn && effA == A_PORTB) portBQ   <= wrData;
         if (wrEn && effA == A_PORTC) portCQ   <= wrData;
         // A TMR0 write wins over an increment and blanks increments for two cycles.
         if (wrEn && effA == A_TMR0) begin
            tmr0Q    <= wrData;
            inhibitQ <= 2'd2;
         end else if (inhibitQ != 2'd0) begin
            inhibitQ <= inhibitQ - 2'd1;
         end else if (bus.tmr0Inc) begin
            tmr0Q <= tmr0Q + DATA_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < GPR_CNT; i++) gprMem[i] <= '0;
      end else if (wrEn && effA >= A_GPR) begin
         gprMem[gprIdx] <= wrData;
      end
   end

   assign bus.gprReadDataOut = rdData;
   assign bus.gprStatusOut   = statusQ;
   assign bus.fsrOut         = fsrQ;
   assign bus.portAOut       = portAQ;
   assign bus.portBOut       = portBQ;
   assign bus.portCOut       = portCQ;
   assign bus.pclWriteEn     = pclEnQ;
   assign bus.pclWriteData   = pclDataQ;
endmodule

// File: tb/tb_gpr_file.sv
// Directed bench for gpr_file: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_gpr_file;
   localparam int K_RD   = 0;
   localparam int K_ST   = 1;
   localparam int K_FSR  = 2;
   localparam int K_PEN  = 3;
   localparam int K_PDAT = 4;
   localparam int K_PA   = 5;
   localparam int K_PB   = 6;

   typedef struct {
      int         kind;
      logic [7:0] exp;
      string      name;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   nTests = 0;
   int   nFail = 0;
   exp_t sb[$];

   gpr_if #(.DATA_WIDTH(8)) bus ();

   gpr_file #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .STATUS_RESET(8'h18)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] actual(input int k);
      case (k)
         K_RD:    return bus.gprReadDataOut;
         K_ST:    return bus.gprStatusOut;
         K_FSR:   return bus.fsrOut;
         K_PEN:   return {7'd0, bus.pclWriteEn};
         K_PDAT:  return bus.pclWriteData;
         K_PA:    return bus.portAOut;
         K_PB:    return bus.portBOut;
         default: return 8'hxx;
      endcase
   endfunction

   initial begin : monitor
      exp_t       e;
      logic [7:0] a;
      forever begin
         @(negedge clk);
         while (sb.size() != 0) begin
            e = sb.pop_front();
            a = actual(e.kind);
            nTests++;
            if (a !== e.exp) begin
               nFail++;
               $display("FAIL %s: got 0x%02h, expected 0x%02h", e.name, a, e.exp);
            end
         end
      end
   end

   task automatic pushExp(input int k, input logic [7:0] v, input string n);
      exp_t e;
      e.kind = k;
      e.exp  = v;
      e.name = n;
      sb.push_back(e);
   endtask

   task automatic cyc(input logic [2:0] c, input logic [7:0] d, input logic [7:0] s,
                      input logic inc);
      bus.writeCommand   = c;
      bus.gprWriteDataIn = d;
      bus.statusWriteIn  = s;
      bus.tmr0Inc        = inc;
      @(posedge clk);
      #1;
      bus.writeCommand = 3'b000;
      bus.tmr0Inc      = 1'b0;
   endtask

   initial begin : stim
      bus.writeCommand   = 3'b000;
      bus.gprWriteDataIn = 8'h00;
      bus.statusWriteIn  = 8'h00;
      bus.tmr0Inc        = 1'b0;
      bus.portAIn        = 8'h3C;
      bus.portBIn        = 8'hA5;
      bus.portCIn        = 8'h00;

      // Reset asserted mid-cycle
      #3 rst_n = 1'b0;
      @(posedge clk); #1;
      pushExp(K_ST,  8'h18, "reset_status");
      pushExp(K_FSR, 8'h00, "reset_fsr");
      pushExp(K_PA,  8'h00, "reset_portAOut");
      pushExp(K_PEN, 8'h00, "reset_pclWriteEn");
      pushExp(K_RD,  8'h00, "reset_read_indf_null");
      @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;

      cyc(3'b100, 8'h0A, 8'h00, 1'b0);
      pushExp(K_RD, 8'h00, "reset_gpr_0A");

      // Direct write
      cyc(3'b010, 8'h5C, 8'h00, 1'b0);
      pushExp(K_RD, 8'h5C, "direct_write_0A");

      // Indirect through FSR
      cyc(3'b100, 8'h04, 8'h00, 1'b0);
      cyc(3'b010, 8'h0C, 8'h00, 1'b0);
      pushExp(K_FSR, 8'h0C, "fsr_write");
      cyc(3'b100, 8'h00, 8'h00, 1'b0);
      cyc(3'b010, 8'h33, 8'h00, 1'b0);
      pushExp(K_RD, 8'h33, "indirect_read");
      cyc(3'b100, 8'h0C, 8'h00, 1'b0);
      pushExp(K_RD, 8'h33, "indirect_landed_0C");
      cyc(3'b100, 8'h04, 8'h00, 1'b0);
      cyc(3'b010, 8'h00, 8'h00, 1'b0);
      pushExp(K_FSR, 8'h00, "fsr_cleared");
      cyc(3'b100, 8'h00, 8'h00, 1'b0);
      cyc(3'b010, 8'h77, 8'h00, 1'b0);
      pushExp(K_RD, 8'h00, "indf_self_read");
      pushExp(K_ST, 8'h18, "indf_self_no_status");
      pushExp(K_FSR, 8'h00, "indf_self_no_fsr");
      cyc(3'b100, 8'h0C, 8'h00, 1'b0);
      pushExp(K_RD, 8'h33, "indf_self_0C_kept");
      cyc(3'b100, 8'h0A, 8'h00, 1'b0);
      pushExp(K_RD, 8'h5C, "indf_self_0A_kept");

      // STATUS merging
      cyc(3'b100, 8'h03, 8'h00, 1'b0);
      cyc(3'b011, 8'hFF, 8'h04, 1'b0);
      pushExp(K_ST, 8'hFC, "status_merge");
      pushExp(K_RD, 8'hFC, "status_read");
      cyc(3'b001, 8'h00, 8'hFB, 1'b0);
      pushExp(K_ST, 8'hFB, "status_flags_only");
      cyc(3'b010, 8'h00, 8'h00, 1'b0);
      pushExp(K_ST, 8'h18, "status_gpr_write_topd_kept");

      // Latch and write together: write goes to old address (STATUS)
      cyc(3'b110, 8'h09, 8'h00, 1'b0);
      pushExp(K_ST, 8'h19, "latch_write_old_addr");
      pushExp(K_RD, 8'h00, "latch_write_new_addr");

      // TMR0 inhibit and wrap
      cyc(3'b100, 8'h01, 8'h00, 1'b0);
      cyc(3'b010, 8'hFF, 8'h00, 1'b0);
      pushExp(K_RD, 8'hFF, "tmr0_write");
      cyc(3'b000, 8'h00, 8'h00, 1'b1);
      pushExp(K_RD, 8'hFF, "tmr0_inhibit1");
      cyc(3'b000, 8'h00, 8'h00, 1'b1);
      pushExp(K_RD, 8'hFF, "tmr0_inhibit2");
      cyc(3'b000, 8'h00, 8'h00, 1'b1);
      pushExp(K_RD, 8'h00, "tmr0_wrap");
      cyc(3'b000, 8'h00, 8'h00, 1'b1);
      pushExp(K_RD, 8'h01, "tmr0_inc");
      cyc(3'b010, 8'h80, 8'h00, 1'b1);
      pushExp(K_RD, 8'h80, "tmr0_write_wins");

      // PCL write pulse
      cyc(3'b100, 8'h02, 8'h00, 1'b0);
      cyc(3'b010, 8'h40, 8'h00, 1'b0);
      pushExp(K_PEN,  8'h01, "pcl_pulse_high");
      pushExp(K_PDAT, 8'h40, "pcl_data");
      pushExp(K_RD,   8'h40, "pcl_read");
      cyc(3'b000, 8'h00, 8'h00, 1'b0);
      pushExp(K_PEN,  8'h00, "pcl_pulse_low");
      pushExp(K_PDAT, 8'h40, "pcl_data_held");

      // Ports read pins, drive latches
      cyc(3'b100, 8'h06, 8'h00, 1'b0);
      cyc(3'b010, 8'h0F, 8'h00, 1'b0);
      pushExp(K_RD, 8'hA5, "portB_read_pins");
      pushExp(K_PB, 8'h0F, "portB_latch");
      pushExp(K_PA, 8'h00, "portA_untouched");
      cyc(3'b100, 8'h05, 8'h00, 1'b0);
      pushExp(K_RD, 8'h3C, "portA_read_pins");

      // Reset during a write
      cyc(3'b100, 8'h10, 8'h00, 1'b0);
      bus.writeCommand   = 3'b010;
      bus.gprWriteDataIn = 8'h99;
      #2 rst_n = 1'b0;
      @(posedge clk); #1;
      bus.writeCommand = 3'b000;
      pushExp(K_RD,   8'h00, "midreset_read");
      pushExp(K_ST,   8'h18, "midreset_status");
      pushExp(K_PB,   8'h00, "midreset_portB");
      pushExp(K_PDAT, 8'h00, "midreset_pcl_data");
      @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      cyc(3'b100, 8'h10, 8'h00, 1'b0);
      pushExp(K_RD, 8'h00, "midreset_write_lost");
      cyc(3'b100, 8'h0A, 8'h00, 1'b0);
      pushExp(K_RD, 8'h00, "midreset_gpr_cleared");
      cyc(3'b100, 8'h01, 8'h00, 1'b0);
      pushExp(K_RD, 8'h00, "midreset_tmr0_cleared");

      repeat (2) @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         nFail++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end
endmodule
